// File: rtl/up_axil_master.sv
// AXI4-Lite slave to up_ipif initiator bridge. Independent write and read FSMs,
// each with an optional ack timeout that answers SLVERR instead of hanging.
module up_axil_master #(
   parameter int C_ADDR_WIDTH = 10,
   parameter int C_DATA_WIDTH = 32,
   parameter int C_TIMEOUT    = 255
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [C_ADDR_WIDTH+1:0]   s_axi_awaddr,
   input  logic                      s_axi_awvalid,
   output logic                      s_axi_awready,
   input  logic [C_DATA_WIDTH-1:0]   s_axi_wdata,
   input  logic [3:0]                s_axi_wstrb,
   input  logic                      s_axi_wvalid,
   output logic                      s_axi_wready,
   output logic [1:0]                s_axi_bresp,
   output logic                      s_axi_bvalid,
   input  logic                      s_axi_bready,
   input  logic [C_ADDR_WIDTH+1:0]   s_axi_araddr,
   input  logic                      s_axi_arvalid,
   output logic                      s_axi_arready,
   output logic [C_DATA_WIDTH-1:0]   s_axi_rdata,
   output logic [1:0]                s_axi_rresp,
   output logic                      s_axi_rvalid,
   input  logic                      s_axi_rready,
   output logic [C_ADDR_WIDTH-1:0]   up_wr_addr,
   output logic [3:0]                up_wr_be,
   output logic                      up_wr_req,
   output logic [C_DATA_WIDTH-1:0]   up_wr_din,
   input  logic                      up_wr_ack,
   output logic [C_ADDR_WIDTH-1:0]   up_rd_addr,
   output logic                      up_rd_req,
   input  logic [C_DATA_WIDTH-1:0]   up_rd_dout,
   input  logic                      up_rd_ack,
   output logic [1:0]                dbg_wr_state,
   output logic [1:0]                dbg_rd_state
);

   // Handshake rule: a transfer happens on a rising edge where valid and ready are both 1.
   localparam int CW = (C_TIMEOUT > 1) ? $clog2(C_TIMEOUT) : 1;
   localparam logic [CW-1:0] TO_LAST = CW'((C_TIMEOUT > 0) ? C_TIMEOUT - 1 : 0);
   localparam bit TO_EN = (C_TIMEOUT != 0);
   localparam logic [1:0] RESP_OKAY = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {W_IDLE = 2'd0, W_REQ = 2'd1, W_RESP = 2'd2} wr_state_t;
   typedef enum logic [1:0] {R_IDLE = 2'd0, R_REQ = 2'd1, R_RESP = 2'd2} rd_state_t;

   wr_state_t wr_state, wr_next;
   rd_state_t rd_state, rd_next;
   logic [CW-1:0] wr_cnt, rd_cnt;
   logic wr_accept, wr_ok, wr_err;
   logic rd_accept, rd_ok, rd_err;

   // Byte-lane bits of the AXI address carry no meaning on the word-addressed side.
   logic unused_addr_bits;
   assign unused_addr_bits = &{1'b0, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

   always_comb begin
      wr_next   = wr_state;
      wr_accept = 1'b0;
      wr_ok     = 1'b0;
      wr_err    = 1'b0;
      case (wr_state)
         W_IDLE: if (s_axi_awvalid && s_axi_wvalid) begin
            wr_accept = 1'b1;
            wr_next   = W_REQ;
         end
         W_REQ: if (up_wr_ack) begin
            wr_ok   = 1'b1;
            wr_next = W_RESP;
         end else if (TO_EN && wr_cnt == TO_LAST) begin
            wr_err  = 1'b1;
            wr_next = W_RESP;
         end
         W_RESP: if (s_axi_bready) wr_next = W_IDLE;
         default: wr_next = W_IDLE;
      endcase
   end

   always_comb begin
      rd_next   = rd_state;
      rd_accept = 1'b0;
      rd_ok     = 1'b0;
      rd_err    = 1'b0;
      case (rd_state)
         R_IDLE: if (s_axi_arvalid) begin
            rd_accept = 1'b1;
            rd_next   = R_REQ;
         end
         R_REQ: if (up_rd_ack) begin
            rd_ok   = 1'b1;
            rd_next = R_RESP;
         end else if (TO_EN && rd_cnt == TO_LAST) begin
            rd_err  = 1'b1;
            rd_next = R_RESP;
         end
         R_RESP: if (s_axi_rready) rd_next = R_IDLE;
         default: rd_next = R_IDLE;
      endcase
   end

   // Readies are gated by rst_n so nothing reads as accepted while held in reset.
   assign s_axi_awready = wr_accept & rst_n;
   assign s_axi_wready  = wr_accept & rst_n;
   assign s_axi_arready = rd_accept & rst_n;
   assign up_wr_req     = (wr_state == W_REQ);
   assign s_axi_bvalid  = (wr_state == W_RESP);
   assign up_rd_req     = (rd_state == R_REQ);
   assign s_axi_rvalid  = (rd_state == R_RESP);
   assign dbg_wr_state  = wr_state;
   assign dbg_rd_state  = rd_state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_state    <= W_IDLE;
         wr_cnt      <= '0;
         up_wr_addr  <= '0;
         up_wr_din   <= '0;
         up_wr_be    <= '0;
         s_axi_bresp <= RESP_OKAY;
      end else begin
         wr_state <= wr_next;
         wr_cnt   <= (wr_state == W_REQ) ? wr_cnt + 1'b1 : '0;
         if (wr_accept) begin
            up_wr_addr <= s_axi_awaddr[C_ADDR_WIDTH+1:2];
            up_wr_din  <= s_axi_wdata;
            up_wr_be   <= s_axi_wstrb;
         end
         if (wr_ok)  s_axi_bresp <= RESP_OKAY;
         if (wr_err) s_axi_bresp <= RESP_SLVERR;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_state    <= R_IDLE;
         rd_cnt      <= '0;
         up_rd_addr  <= '0;
         s_axi_rdata <= '0;
         s_axi_rresp <= RESP_OKAY;
      end else begin
         rd_state <= rd_next;
         rd_cnt   <= (rd_state == R_REQ) ? rd_cnt + 1'b1 : '0;
         if (rd_accept) up_rd_addr <= s_axi_araddr[C_ADDR_WIDTH+1:2];
         if (rd_ok) begin
            s_axi_rdata <= up_rd_dout;
            s_axi_rresp <= RESP_OKAY;
         end
         if (rd_err) begin
            s_axi_rdata <= '0;
            s_axi_rresp <= RESP_SLVERR;
         end
      end
   end

endmodule

// File: tb/tb_up_axil_master.sv
// Directed bench for up_axil_master: a vector table of single transactions
// plus hand-written sequences for stalls, concurrency, late acks and reset.
module tb_up_axil_master;
   localparam int AW = 10;
   localparam int TO = 16;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [AW+1:0] s_axi_awaddr, s_axi_araddr;
   logic s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
   logic [31:0] s_axi_wdata, s_axi_rdata;
   logic [3:0] s_axi_wstrb;
   logic [1:0] s_axi_bresp, s_axi_rresp;
   logic s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
   logic s_axi_rvalid, s_axi_rready;
   logic [AW-1:0] up_wr_addr, up_rd_addr;
   logic [3:0] up_wr_be;
   logic up_wr_req, up_wr_ack, up_rd_req, up_rd_ack;
   logic [31:0] up_wr_din, up_rd_dout;
   logic [1:0] dbg_wr_state, dbg_rd_state;

   up_axil_master #(.C_ADDR_WIDTH(AW), .C_DATA_WIDTH(32), .C_TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
      .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
      .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
      .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
      .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
      .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
      .up_wr_addr(up_wr_addr), .up_wr_be(up_wr_be), .up_wr_req(up_wr_req),
      .up_wr_din(up_wr_din), .up_wr_ack(up_wr_ack), .up_rd_addr(up_rd_addr),
      .up_rd_req(up_rd_req), .up_rd_dout(up_rd_dout), .up_rd_ack(up_rd_ack),
      .dbg_wr_state(dbg_wr_state), .dbg_rd_state(dbg_rd_state)
   );

   int n_cmp = 0;
   int n_err = 0;
   logic [33:0] exp_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct {
      bit          is_wr;
      logic [11:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      int          ack_at;    // 1-based req cycle carrying the ack, 0 = never
      logic [9:0]  exp_addr;
      logic [31:0] exp_data;  // up_wr_din for writes, rdata for reads
      logic [1:0]  exp_resp;
      int          exp_req;
   } vec_t;
   vec_t vecs[7];

   task automatic idle_inputs();
      s_axi_awaddr = '0; s_axi_awvalid = 0; s_axi_wdata = '0; s_axi_wstrb = '0;
      s_axi_wvalid = 0; s_axi_bready = 0; s_axi_araddr = '0; s_axi_arvalid = 0;
      s_axi_rready = 0; up_wr_ack = 0; up_rd_ack = 0; up_rd_dout = 32'hBAD0_BAD0;
   endtask

   task automatic wr_issue(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
      @(negedge clk);
      s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
      s_axi_awvalid = 1; s_axi_wvalid = 1;
      #1;
      check("awready", s_axi_awready, 1);
      check("wready", s_axi_wready, 1);
      @(negedge clk);
      s_axi_awvalid = 0; s_axi_wvalid = 0;
      #1;
   endtask

   task automatic wr_req_phase(input int ack_at, input logic [9:0] ea, input logic [31:0] ed,
                               input logic [3:0] eb, input int ereq);
      int n = 0;
      for (int c = 0; c < 40; c++) begin
         if (up_wr_req !== 1'b1) break;
         n++;
         check("up_wr_addr", up_wr_addr, ea);
         check("up_wr_din", up_wr_din, ed);
         check("up_wr_be", up_wr_be, eb);
         up_wr_ack = (n == ack_at);
         @(negedge clk);
         up_wr_ack = 0;
         #1;
      end
      check("wr_req_cycles", n, ereq);
   endtask

   task automatic wr_resp(input logic [1:0] er);
      check("bvalid", s_axi_bvalid, 1);
      check("bresp", s_axi_bresp, er);
      s_axi_bready = 1;
      @(negedge clk);
      s_axi_bready = 0;
      #1;
      check("bvalid_drop", s_axi_bvalid, 0);
   endtask

   task automatic rd_issue(input logic [11:0] a);
      @(negedge clk);
      s_axi_araddr = a; s_axi_arvalid = 1;
      #1;
      check("arready", s_axi_arready, 1);
      @(negedge clk);
      s_axi_arvalid = 0;
      #1;
   endtask

   task automatic rd_req_phase(input int ack_at, input logic [9:0] ea, input logic [31:0] d,
                               input int ereq);
      int n = 0;
      for (int c = 0; c < 40; c++) begin
         if (up_rd_req !== 1'b1) break;
         n++;
         check("up_rd_addr", up_rd_addr, ea);
         up_rd_ack  = (n == ack_at);
         up_rd_dout = (n == ack_at) ? d : 32'hBAD0_BAD0;
         @(negedge clk);
         up_rd_ack = 0;
         up_rd_dout = 32'hBAD0_BAD0;
         #1;
      end
      check("rd_req_cycles", n, ereq);
   endtask

   task automatic rd_resp();
      logic [33:0] e;
      if (exp_q.size() == 0) begin
         check("rd_exp_q_empty", 1, 0);
         return;
      end
      e = exp_q.pop_front();
      check("rvalid", s_axi_rvalid, 1);
      check("rresp", s_axi_rresp, e[33:32]);
      check("rdata", s_axi_rdata, e[31:0]);
      s_axi_rready = 1;
      @(negedge clk);
      s_axi_rready = 0;
      #1;
      check("rvalid_drop", s_axi_rvalid, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{1, 12'h010, 32'hDEADBEEF, 4'hF, 3,  10'h004, 32'hDEADBEEF, 2'b00, 3};
      vecs[1] = '{0, 12'h01C, 32'h12345678, 4'h0, 1,  10'h007, 32'h12345678, 2'b00, 1};
      vecs[2] = '{1, 12'hFFF, 32'h0BADF00D, 4'h5, 1,  10'h3FF, 32'h0BADF00D, 2'b00, 1};
      vecs[3] = '{0, 12'h003, 32'hA5A5A5A5, 4'h0, 16, 10'h000, 32'hA5A5A5A5, 2'b00, 16};
      vecs[4] = '{1, 12'h204, 32'h00000001, 4'h2, 0,  10'h081, 32'h00000001, 2'b10, 16};
      vecs[5] = '{1, 12'h3F8, 32'h76543210, 4'h8, 16, 10'h0FE, 32'h76543210, 2'b00, 16};
      vecs[6] = '{0, 12'h01C, 32'h12345678, 4'h0, 0,  10'h007, 32'h00000000, 2'b10, 16};

      // Reset values, including readies while valids are presented in reset.
      rst_n = 0;
      idle_inputs();
      #1;
      check("rst_bvalid", s_axi_bvalid, 0);
      check("rst_rvalid", s_axi_rvalid, 0);
      check("rst_wr_req", up_wr_req, 0);
      check("rst_rd_req", up_rd_req, 0);
      check("rst_rdata", s_axi_rdata, 0);
      check("rst_wr_addr", up_wr_addr, 0);
      s_axi_awvalid = 1; s_axi_wvalid = 1; s_axi_arvalid = 1;
      #1;
      check("rst_awready", s_axi_awready, 0);
      check("rst_arready", s_axi_arready, 0);
      idle_inputs();
      repeat (3) @(negedge clk);
      rst_n = 1;

      for (int i = 0; i < 7; i++) begin
         if (vecs[i].is_wr) begin
            wr_issue(vecs[i].addr, vecs[i].data, vecs[i].strb);
            wr_req_phase(vecs[i].ack_at, vecs[i].exp_addr, vecs[i].exp_data,
                         vecs[i].strb, vecs[i].exp_req);
            wr_resp(vecs[i].exp_resp);
         end else begin
            exp_q.push_back({vecs[i].exp_resp, vecs[i].exp_data});
            rd_issue(vecs[i].addr);
            rd_req_phase(vecs[i].ack_at, vecs[i].exp_addr, vecs[i].data, vecs[i].exp_req);
            rd_resp();
         end
      end

      // A late read ack after the timeout response must not produce anything.
      repeat (3) @(negedge clk);
      up_rd_ack = 1; up_rd_dout = 32'hFFFF_FFFF;
      @(negedge clk);
      up_rd_ack = 0; up_rd_dout = 32'hBAD0_BAD0;
      #1;
      for (int c = 0; c < 5; c++) begin
         check("late_ack_rvalid", s_axi_rvalid, 0);
         check("late_ack_rd_req", up_rd_req, 0);
         @(negedge clk);
         #1;
      end
      check("late_ack_rd_state", dbg_rd_state, 0);

      // AW arrives five cycles before W: no partial accept.
      @(negedge clk);
      s_axi_awaddr = 12'h020; s_axi_awvalid = 1;
      s_axi_wdata = 32'hC0FFEE00; s_axi_wstrb = 4'h3;
      for (int c = 0; c < 5; c++) begin
         #1;
         check("stall_awready", s_axi_awready, 0);
         check("stall_wready", s_axi_wready, 0);
         @(negedge clk);
      end
      s_axi_wvalid = 1;
      #1;
      check("joint_awready", s_axi_awready, 1);
      check("joint_wready", s_axi_wready, 1);
      @(negedge clk);
      s_axi_awvalid = 0; s_axi_wvalid = 0;
      #1;
      wr_req_phase(1, 10'h008, 32'hC0FFEE00, 4'h3, 1);
      for (int c = 0; c < 10; c++) begin
         check("hold_bvalid", s_axi_bvalid, 1);
         check("hold_bresp", s_axi_bresp, 2'b00);
         @(negedge clk);
         #1;
      end
      wr_resp(2'b00);

      // Write and read in the same cycle, read acked first.
      @(negedge clk);
      s_axi_awaddr = 12'h040; s_axi_wdata = 32'h11112222; s_axi_wstrb = 4'hF;
      s_axi_awvalid = 1; s_axi_wvalid = 1;
      s_axi_araddr = 12'h080; s_axi_arvalid = 1;
      #1;
      check("conc_awready", s_axi_awready, 1);
      check("conc_arready", s_axi_arready, 1);
      @(negedge clk);
      s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_arvalid = 0;
      #1;
      check("conc_wr_req", up_wr_req, 1);
      check("conc_rd_req", up_rd_req, 1);
      check("conc_wr_addr", up_wr_addr, 10'h010);
      check("conc_rd_addr", up_rd_addr, 10'h020);
      up_rd_ack = 1; up_rd_dout = 32'hCAFEF00D;
      @(negedge clk);
      up_rd_ack = 0; up_rd_dout = 32'hBAD0_BAD0;
      #1;
      check("conc_rvalid", s_axi_rvalid, 1);
      check("conc_rdata", s_axi_rdata, 32'hCAFEF00D);
      check("conc_rd_req_off", up_rd_req, 0);
      check("conc_wr_req_on", up_wr_req, 1);
      check("conc_bvalid_early", s_axi_bvalid, 0);
      up_wr_ack = 1;
      @(negedge clk);
      up_wr_ack = 0;
      #1;
      check("conc_bvalid", s_axi_bvalid, 1);
      check("conc_bresp", s_axi_bresp, 2'b00);
      check("conc_rvalid_held", s_axi_rvalid, 1);
      check("conc_rdata_held", s_axi_rdata, 32'hCAFEF00D);
      check("conc_rresp", s_axi_rresp, 2'b00);
      s_axi_bready = 1; s_axi_rready = 1;
      @(negedge clk);
      s_axi_bready = 0; s_axi_rready = 0;
      #1;
      check("conc_bvalid_drop", s_axi_bvalid, 0);
      check("conc_rvalid_drop", s_axi_rvalid, 0);

      // Reset while a write request is outstanding.
      wr_issue(12'h100, 32'h89ABCDEF, 4'hF);
      check("pre_rst_wr_req", up_wr_req, 1);
      rst_n = 0;
      #1;
      check("mid_rst_wr_req", up_wr_req, 0);
      check("mid_rst_wr_addr", up_wr_addr, 0);
      check("mid_rst_wr_din", up_wr_din, 0);
      check("mid_rst_wr_be", up_wr_be, 0);
      check("mid_rst_bvalid", s_axi_bvalid, 0);
      check("mid_rst_wr_state", dbg_wr_state, 0);
      s_axi_awvalid = 1; s_axi_wvalid = 1;
      #1;
      check("mid_rst_awready", s_axi_awready, 0);
      s_axi_awvalid = 0; s_axi_wvalid = 0;
      repeat (2) @(negedge clk);
      rst_n = 1;
      #1;
      check("post_rst_bvalid", s_axi_bvalid, 0);
      wr_issue(12'h104, 32'h55AA55AA, 4'hF);
      wr_req_phase(2, 10'h041, 32'h55AA55AA, 4'hF, 2);
      wr_resp(2'b00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
